// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select type, per-rate clock-per-tick factors and the tx FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
    localparam int unsigned OS_TICKS         = 16;

    typedef logic [1:0] baud_sel_t;

    localparam baud_sel_t BAUD_9600   = 2'd0;
    localparam baud_sel_t BAUD_19200  = 2'd1;
    localparam baud_sel_t BAUD_57600  = 2'd2;
    localparam baud_sel_t BAUD_115200 = 2'd3;

    // Clock cycles per oversample tick, truncated.
    function automatic logic [10:0] calc_factor(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned os);
        return 11'(clk_freq / (baud * os));
    endfunction

    localparam logic [10:0] FF_9600   = calc_factor(CLK_FREQ_DEFAULT, 32'd9600,   OS_TICKS);
    localparam logic [10:0] FF_19200  = calc_factor(CLK_FREQ_DEFAULT, 32'd19200,  OS_TICKS);
    localparam logic [10:0] FF_57600  = calc_factor(CLK_FREQ_DEFAULT, 32'd57600,  OS_TICKS);
    localparam logic [10:0] FF_115200 = calc_factor(CLK_FREQ_DEFAULT, 32'd115200, OS_TICKS);

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..period-1 and flags the wrap cycle.
// pre_tick flags the cycle just before the tick so callers can register tick-aligned outputs.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [10:0] period,
    output logic        tick,
    output logic        pre_tick
);

    logic [10:0] cnt_r;
    logic        wrap_s;

    assign wrap_s   = (cnt_r >= (period - 11'd1));
    assign tick     = wrap_s;
    assign pre_tick = (cnt_r == (period - 11'd2));

    // Free-running tick counter, restarted when a new frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 11'd0;
        end else if (clear) begin
            cnt_r <= 11'd0;
        end else if (wrap_s) begin
            cnt_r <= 11'd0;
        end else begin
            cnt_r <= cnt_r + 11'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, 8N1 by default, 8E1 when
// UART_TX_PARITY_EN is defined. Bit time is 16 ticks of the selected baud factor.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  brate_selection,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        tx_output,
    output logic [10:0] freq_factor
);

    localparam logic [10:0] FACTOR_0 = calc_factor(CLK_FREQ, 32'd9600,   OVERSAMPLE);
    localparam logic [10:0] FACTOR_1 = calc_factor(CLK_FREQ, 32'd19200,  OVERSAMPLE);
    localparam logic [10:0] FACTOR_2 = calc_factor(CLK_FREQ, 32'd57600,  OVERSAMPLE);
    localparam logic [10:0] FACTOR_3 = calc_factor(CLK_FREQ, 32'd115200, OVERSAMPLE);
    localparam logic [3:0]  TPB_LAST = 4'(OVERSAMPLE - 1);

    function automatic logic [10:0] factor_for(input baud_sel_t sel);
        case (sel)
            BAUD_9600:   return FACTOR_0;
            BAUD_19200:  return FACTOR_1;
            BAUD_57600:  return FACTOR_2;
            BAUD_115200: return FACTOR_3;
            default:     return FACTOR_0;
        endcase
    endfunction

    tx_state_t   state_r, state_next_s;
    logic [7:0]  shift_r, shift_next_s;
    logic [2:0]  bit_idx_r, bit_idx_next_s;
    logic [3:0]  tpb_r, tpb_next_s;
    baud_sel_t   rate_r, rate_next_s;
    logic [10:0] freq_factor_r;
    logic        tx_output_r, tx_output_s;
    logic        tx_ready_r, tx_ready_s;
    logic        tx_done_r, tx_done_s;
    logic        accept_s;
    logic        bit_end_s;
    logic        tick_s;
    logic        pre_tick_s;
    logic        parity_r, parity_next_s;

    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_s),
        .period   (freq_factor_r),
        .tick     (tick_s),
        .pre_tick (pre_tick_s)
    );

    // Next-state, datapath and next-output decode; outputs are derived from the next state
    // so the registered line changes on the same edge as the state.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        rate_next_s    = rate_r;
        parity_next_s  = parity_r;
        accept_s       = 1'b0;
        tx_done_s      = 1'b0;
        tx_output_s    = 1'b1;
        bit_end_s      = tick_s && (tpb_r == TPB_LAST);
        if (tick_s) begin
            tpb_next_s = tpb_r + 4'd1;
        end else begin
            tpb_next_s = tpb_r;
        end

        case (state_r)
            ST_IDLE: begin
                tpb_next_s = 4'd0;
                if (tx_valid && tx_ready_r) begin
                    accept_s       = 1'b1;
                    state_next_s   = ST_START;
                    shift_next_s   = tx_data;
                    rate_next_s    = brate_selection;
                    bit_idx_next_s = 3'd0;
                    parity_next_s  = even_parity(tx_data);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else if (bit_end_s) begin
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // tx_done is registered, so raise it one cycle ahead to land on the last stop cycle.
                if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                end else if (pre_tick_s && (tpb_r == TPB_LAST)) begin
                    tx_done_s = 1'b1;
                end else begin
                    tx_done_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        case (state_next_s)
            ST_IDLE:   tx_output_s = 1'b1;
            ST_START:  tx_output_s = 1'b0;
            ST_DATA:   tx_output_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_output_s = parity_next_s;
`endif
            ST_STOP:   tx_output_s = 1'b1;
            default:   tx_output_s = 1'b1;
        endcase

        tx_ready_s = (state_next_s == ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            shift_r       <= 8'd0;
            bit_idx_r     <= 3'd0;
            tpb_r         <= 4'd0;
            rate_r        <= BAUD_9600;
            freq_factor_r <= FACTOR_0;
            tx_output_r   <= 1'b1;
            tx_ready_r    <= 1'b1;
            tx_done_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            shift_r       <= shift_next_s;
            bit_idx_r     <= bit_idx_next_s;
            tpb_r         <= tpb_next_s;
            rate_r        <= rate_next_s;
            freq_factor_r <= factor_for(rate_next_s);
            tx_output_r   <= tx_output_s;
            tx_ready_r    <= tx_ready_s;
            tx_done_r     <= tx_done_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted byte, held for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_next_s;
        end
    end
`else
    assign parity_r = 1'b0;
`endif

    assign tx_output   = tx_output_r;
    assign tx_ready    = tx_ready_r;
    assign tx_done     = tx_done_r;
    assign freq_factor = freq_factor_r;

endmodule
